elastic_pipeline: RTL

//  Backpressure-aware counterpart to the fixed delay line: a STAGES-deep

---
 rtl/util_pkg.sv | 10 +
 rtl/skid_buffer.sv | 45 ++++
 rtl/elastic_pipeline.sv | 115 +++++++++++
 3 files changed

// File: rtl/util_pkg.sv
// Shared helpers for the elastic pipeline.
//   count_w(stages) : width of a counter that must hold 0..stages+1
//                     (all register stages plus the skid slot).
package util_pkg;

  function automatic int count_w(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Single-entry skid buffer with a registered upstream ready.
// When empty, the upstream word passes straight through to the downstream
// side. If the downstream side refuses a word that was accepted upstream, the
// word is parked here and up_ready drops on the following cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   up_valid, up_data   producer side
//   up_ready            producer may transfer (registered: buffer not full)
//   dn_valid, dn_data   word offered to the downstream stage
//   dn_ready            downstream stage takes the offered word this cycle
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);

  logic             full;
  logic [WIDTH-1:0] held;

  // up_ready comes straight from a flop, so no combinational ready path
  // crosses from the downstream side to the producer.
  assign up_ready = !full;
  assign dn_valid = full || up_valid;
  assign dn_data  = full ? held : up_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      held <= '0;
    end else if (full) begin
      if (dn_ready) full <= 1'b0;
    end else if (up_valid && !dn_ready) begin
      full <= 1'b1;
      held <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// STAGES-deep valid/ready register pipeline with a skid buffer at the input.
// Empty stages always accept (bubbles collapse), so a stalled consumer lets
// the pipeline pack up to STAGES+1 words before ready_out drops.
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset (sync release)
//   valid_in, data_in producer side; ready_out is registered
//   valid_out, data_out, ready_in  consumer side
//   count_out         words held (skid + stages), registered
module elastic_pipeline
  import util_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  input  logic [WIDTH-1:0]            data_in,
  output logic                        ready_out,
  output logic                        valid_out,
  output logic [WIDTH-1:0]            data_out,
  input  logic                        ready_in,
  output logic [count_w(STAGES)-1:0]  count_out
);

  localparam int COUNT_W = count_w(STAGES);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [STAGES:0]  adv;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0] d [STAGES];

  skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .up_valid (valid_in),
    .up_data  (data_in),
    .up_ready (ready_out),
    .dn_valid (skid_valid),
    .dn_data  (skid_data),
    .dn_ready (adv[0])
  );

  // A stage advances if it is empty or the stage after it advances; the
  // chain is computed in one block from the registered valids.
  always_comb begin
    adv[STAGES] = ready_in;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !v[i] || adv[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (i == 0) begin : g_head
      assign up_v = skid_valid;
      assign up_d = skid_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    // Data only loads with a valid word so data_out keeps its last value
    // once the pipeline drains.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (adv[i]) begin
        v_q <= up_v;
        if (up_v) d_q <= up_d;
      end
    end

    assign v[i] = v_q;
    assign d[i] = d_q;
  end

  assign valid_out = v[STAGES-1];
  assign data_out  = d[STAGES-1];

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = valid_in && ready_out;
  assign out_xfer = valid_out && ready_in;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
    end else if (in_xfer && !out_xfer) begin
      count_out <= count_out + COUNT_ONE;
    end else if (out_xfer && !in_xfer) begin
      count_out <= count_out - COUNT_ONE;
    end
  end

endmodule
